// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the asyncMem port arbiter:
//   - arb_state_t : 2-bit FSM state encoding (IDLE / ACCESS / DONE)
//   - DEF_AW/DEF_DW : default address and data widths of the memory
//   - MAX_NREQ : largest supported requester count
//   - idx_to_onehot() : requester index to one-hot requester mask
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int DEF_AW   = 8;
  localparam int DEF_DW   = 8;
  localparam int MAX_NREQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_t;

  // Returns a MAX_NREQ-wide mask; callers size-cast it down to NREQ bits.
  function automatic logic [MAX_NREQ-1:0] idx_to_onehot(input logic [1:0] idx);
    return MAX_NREQ'(1) << idx;
  endfunction

endpackage : mem_arb_pkg

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin search. Starting at i_ptr and walking upwards
// with wrap-around, reports the first requester whose request bit is set.
//   i_req   : request vector, one bit per requester
//   i_ptr   : index with highest priority this round
//   o_idx   : winning requester index (0 when o_valid is low)
//   o_valid : at least one request is pending
// ---------------------------------------------------------------------------
module rr_picker #(
  parameter int NREQ = 3,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [PW-1:0]   o_idx,
  output logic            o_valid
);

  int          w_cand;
  logic [PW-1:0] w_cand_idx;

  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    o_idx      = '0;
    o_valid    = 1'b0;
    w_cand     = 0;
    w_cand_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      // ptr + k is below 2*NREQ, so one conditional subtract is the modulo.
      w_cand = int'(i_ptr) + k;
      if (w_cand >= NREQ) begin
        w_cand = w_cand - NREQ;
      end
      w_cand_idx = PW'(w_cand);
      if (!o_valid && i_req[w_cand_idx]) begin
        o_valid = 1'b1;
        o_idx   = w_cand_idx;
      end
    end
  end

endmodule : rr_picker

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single asynchronous port of asyncMem between NREQ requesters
// with round-robin arbitration. Each granted request gets one ACCESS cycle
// on the memory pins and a one-cycle acknowledge (DONE) carrying read data.
//
// Ports
//   clk           : system clock, rising-edge active
//   reset         : asynchronous active-low reset
//   req           : per-requester access request (level)
//   req_we        : per-requester write (1) / read (0)
//   req_addr      : packed addresses, requester i at [i*AW +: AW]
//   req_wdata     : packed write data, same packing
//   gnt           : one-hot grant, high during the ACCESS cycle
//   ack           : one-hot completion, high during the DONE cycle
//   rdata         : read data, valid while ack is high
//   busy          : arbiter is not IDLE
//   mem_address   : memory address pin
//   mem_data_in   : memory write data pin
//   mem_write_en  : memory write enable pin
//   mem_data_out  : memory read data pin
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [DW-1:0]     rdata,
  output logic              busy,
  output logic [AW-1:0]     mem_address,
  output logic [DW-1:0]     mem_data_in,
  output logic              mem_write_en,
  input  logic [DW-1:0]     mem_data_out
);

  localparam int PW = $clog2(NREQ);

  // State, pointer and winner latch
  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_idx;

  // Registered outputs; the mem_* registers double as the latched
  // address / write data / write enable of the granted request.
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_ack;
  logic [DW-1:0]   r_rdata;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_din;
  logic            r_mem_we;

  // Next values of the registered outputs
  logic [NREQ-1:0] w_gnt_nxt;
  logic [NREQ-1:0] w_ack_nxt;
  logic [DW-1:0]   w_rdata_nxt;
  logic [AW-1:0]   w_mem_addr_nxt;
  logic [DW-1:0]   w_mem_din_nxt;
  logic            w_mem_we_nxt;

  // Arbitration
  logic [PW-1:0] w_pick_idx;
  logic          w_pick_valid;
  logic          w_take;
  logic [PW-1:0] w_ptr_after;

  rr_picker #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_picker (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // Requests are only looked at in IDLE and DONE; ACCESS ignores them.
  assign w_take = w_pick_valid && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // Priority moves to the requester just after the winner.
  assign w_ptr_after = (int'(w_pick_idx) == NREQ - 1) ? '0 : w_pick_idx + PW'(1);

  // -------------------------------------------------------------------------
  // State register (with round-robin pointer and winner index)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      r_state <= w_state_nxt;
      if (w_take) begin
        r_ptr <= w_ptr_after;
        r_idx <= w_pick_idx;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = ST_IDLE;
    unique case (r_state)
      ST_IDLE:   w_state_nxt = w_pick_valid ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = w_pick_valid ? ST_ACCESS : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: next values for the output registers. Everything defaults
  // to zero so the memory pins sit at 0 outside ACCESS and gnt/ack are
  // single-cycle pulses; rdata defaults to holding its value.
  // -------------------------------------------------------------------------
  always_comb begin
    w_gnt_nxt      = '0;
    w_ack_nxt      = '0;
    w_rdata_nxt    = r_rdata;
    w_mem_addr_nxt = '0;
    w_mem_din_nxt  = '0;
    w_mem_we_nxt   = 1'b0;

    // Entering ACCESS: present the winner's request on the memory pins.
    if (w_take) begin
      w_gnt_nxt      = NREQ'(idx_to_onehot(2'(w_pick_idx)));
      w_mem_addr_nxt = req_addr[w_pick_idx*AW +: AW];
      w_mem_din_nxt  = req_wdata[w_pick_idx*DW +: DW];
      w_mem_we_nxt   = req_we[w_pick_idx];
    end

    // Leaving ACCESS: acknowledge, and capture read data from the memory
    // while the address is still applied.
    if (r_state == ST_ACCESS) begin
      w_ack_nxt = NREQ'(idx_to_onehot(2'(r_idx)));
      if (!r_mem_we) begin
        w_rdata_nxt = mem_data_out;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output registers: all memory pins come straight from flops, so the
  // asynchronous memory never sees a combinational glitch on write enable.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gnt      <= '0;
      r_ack      <= '0;
      r_rdata    <= '0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_mem_we   <= 1'b0;
    end else begin
      r_gnt      <= w_gnt_nxt;
      r_ack      <= w_ack_nxt;
      r_rdata    <= w_rdata_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_mem_din  <= w_mem_din_nxt;
      r_mem_we   <= w_mem_we_nxt;
    end
  end

  assign gnt          = r_gnt;
  assign ack          = r_ack;
  assign rdata        = r_rdata;
  assign busy         = (r_state != ST_IDLE);
  assign mem_address  = r_mem_addr;
  assign mem_data_in  = r_mem_din;
  assign mem_write_en = r_mem_we;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter (NREQ=3, AW=DW=8). Drives inputs
// and samples outputs on the falling clock edge. The reference model is a
// flat memory array plus a rotating-priority search over the request mask.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 8;
  localparam int DW   = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic [DW-1:0]     rdata;
  logic              busy;
  logic [AW-1:0]     mem_address;
  logic [DW-1:0]     mem_data_in;
  logic              mem_write_en;
  logic [DW-1:0]     mem_data_out;

  mem_port_arbiter #(
    .NREQ (NREQ),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .gnt          (gnt),
    .ack          (ack),
    .rdata        (rdata),
    .busy         (busy),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_write_en (mem_write_en),
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  // Power-up contents of the memory: a fixed pattern, with 0xA7 at 0x05.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 8'h05) return 8'hA7;
    return DW'(a) ^ 8'h5A;
  endfunction

  // asyncMem stand-in: asynchronous read, write committed while enabled.
  bit [DW-1:0] tb_mem     [256];
  bit          tb_written [256];
  assign mem_data_out = tb_written[mem_address] ? tb_mem[mem_address] : init_val(mem_address);

  always @(posedge clk) begin
    if (mem_write_en === 1'b1) begin
      tb_mem[mem_address]     <= mem_data_in;
      tb_written[mem_address] <= 1'b1;
    end
  end

  int we_cnt = 0;
  always @(posedge clk) if (mem_write_en === 1'b1) we_cnt <= we_cnt + 1;

  // Reference model state
  logic [DW-1:0] ref_mem [256];
  int            m_ptr;
  logic [DW-1:0] m_rdata;

  // Per-requester stimulus fields
  logic          b_we    [NREQ];
  logic [AW-1:0] b_addr  [NREQ];
  logic [DW-1:0] b_wdata [NREQ];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // First requester in mask, searching p, p+1, ... modulo NREQ.
  function automatic int ref_pick(input logic [NREQ-1:0] mask, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (mask[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic drive(input logic [NREQ-1:0] mask);
    req = mask;
    for (int i = 0; i < NREQ; i++) begin
      req_we[i]              = b_we[i];
      req_addr[i*AW +: AW]   = b_addr[i];
      req_wdata[i*DW +: DW]  = b_wdata[i];
    end
  endtask

  task automatic check_quiet(input string tag);
    check(tag, {busy, gnt, ack, mem_address, mem_data_in, mem_write_en}, 32'h0);
  endtask

  // One isolated transaction: request, ACCESS, DONE, back to IDLE.
  task automatic run_txn(input logic [NREQ-1:0] mask);
    int w;
    w = ref_pick(mask, m_ptr);
    drive(mask);
    @(negedge clk);
    check("gnt",      gnt,          32'(1) << w);
    check("busy_acc", busy,         1);
    check("mem_addr", mem_address,  b_addr[w]);
    check("mem_din",  mem_data_in,  b_wdata[w]);
    check("mem_we",   mem_write_en, b_we[w]);
    req = '0;
    if (b_we[w]) ref_mem[b_addr[w]] = b_wdata[w];
    else         m_rdata = ref_mem[b_addr[w]];
    m_ptr = (w + 1) % NREQ;
    @(negedge clk);
    check("ack",         ack,   32'(1) << w);
    check("rdata",       rdata, m_rdata);
    check("done_no_gnt", {gnt, mem_address, mem_data_in, mem_write_en}, 32'h0);
    @(negedge clk);
    check("busy_idle", busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
    @(negedge clk);
    check_quiet("reset_quiet");
    check("reset_rdata", rdata, 0);
    reset   = 1'b1;
    m_ptr   = 0;
    m_rdata = '0;
  endtask

  initial begin
    int base_we;
    logic [NREQ-1:0] mask;

    reset     = 1'b0;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(AW'(i));
    for (int i = 0; i < NREQ; i++) begin
      b_we[i] = 1'b0; b_addr[i] = '0; b_wdata[i] = '0;
    end
    m_ptr   = 0;
    m_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_quiet("por_quiet");
    check("por_rdata", rdata, 0);
    reset = 1'b1;
    @(negedge clk);

    // Requester 0 reads 0x05
    b_addr[0] = 8'h05; b_we[0] = 1'b0;
    run_txn(3'b001);
    check("t1_rdata_a7", rdata, 8'hA7);
    check("t1_no_write", we_cnt, 0);

    // Requester 1 writes 0x3C to 0x02, then reads it back
    base_we = we_cnt;
    b_we[1] = 1'b1; b_addr[1] = 8'h02; b_wdata[1] = 8'h3C;
    run_txn(3'b010);
    check("t2_we_once", we_cnt - base_we, 1);
    b_we[1] = 1'b0;
    run_txn(3'b010);
    check("t2_rdata_3c", rdata, 8'h3C);
    check("t2_we_total", we_cnt - base_we, 1);

    // All requests held high: order 0,1,2,0,1 at 2-cycle spacing
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      b_we[i] = 1'b0; b_addr[i] = AW'(8'h10 + i);
    end
    drive(3'b111);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rr_gnt",  gnt,  32'(1) << (k % NREQ));
      check("rr_busy", busy, 1);
      @(negedge clk);
      check("rr_ack",   ack,   32'(1) << (k % NREQ));
      check("rr_busy",  busy,  1);
      check("rr_rdata", rdata, ref_mem[b_addr[k % NREQ]]);
      if (k == 4) req = '0;
    end
    @(negedge clk);
    check("rr_idle", busy, 0);
    m_ptr   = 2;
    m_rdata = ref_mem[b_addr[1]];

    // Pointer at 2 with req=011: wraps to 0, then 1
    drive(3'b011);
    @(negedge clk);
    check("wrap_gnt0", gnt, 3'b001);
    @(negedge clk);
    check("wrap_ack0", ack, 3'b001);
    @(negedge clk);
    check("wrap_gnt1", gnt, 3'b010);
    req = '0;
    @(negedge clk);
    check("wrap_ack1", ack, 3'b010);
    @(negedge clk);
    check("wrap_idle", busy, 0);
    m_ptr   = 2;
    m_rdata = ref_mem[b_addr[1]];

    // Reset in the middle of a write ACCESS
    b_we[0] = 1'b1; b_addr[0] = 8'h40; b_wdata[0] = 8'h99;
    drive(3'b001);
    @(negedge clk);
    check("mid_we_high", mem_write_en, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_we_drop", mem_write_en, 0);
    check_quiet("mid_quiet");
    check("mid_rdata", rdata, 0);
    req = '0;
    @(negedge clk);
    check("mid_no_ack", ack, 0);
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) b_we[i] = 1'b0;
    m_ptr   = 0;
    m_rdata = '0;
    drive(3'b111);
    @(negedge clk);
    check("post_rst_gnt", gnt, 3'b001);
    check("post_rst_ack", ack, 0);
    req = '0;
    @(negedge clk);
    check("post_rst_ack0", ack,   3'b001);
    check("post_rst_rd",   rdata, ref_mem[b_addr[0]]);
    m_rdata = ref_mem[b_addr[0]];
    m_ptr   = 1;
    @(negedge clk);
    check("post_rst_idle", busy, 0);

    // Idle for 10 cycles
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_quiet("idle_quiet");
    end

    // Randomized transactions against the model
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        b_we[i]    = 1'($urandom);
        b_addr[i]  = AW'($urandom_range(0, 31));
        b_wdata[i] = DW'($urandom);
      end
      mask = NREQ'($urandom_range(1, 7));
      run_txn(mask);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule : tb_mem_port_arbiter
